// File: rtl/pea_wb_pkg.sv
// Shared types for the PE-array output writeback stage.
package pea_wb_pkg;

    // Default geometry of the PE array output vector
    localparam int PEA_N_PE = 8;
    localparam int PEA_WID  = 16;

    // Job sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One PE output word
    typedef logic [PEA_WID-1:0] lane_word_t;

    // One full PE output vector, lane i at index i
    typedef lane_word_t [PEA_N_PE-1:0] vec_t;

endpackage

// File: rtl/pea_vec_fifo.sv
// Small synchronous FIFO holding whole PE output vectors.
module pea_vec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // Storage array; contents need no reset because occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pea_output_writeback.sv
// Collects PE output vectors and serializes the enabled lanes into
// single-word writes towards the output feature-map buffer.
module pea_output_writeback
    import pea_wb_pkg::*;
#(
    parameter int N_PE   = PEA_N_PE,
    parameter int WID    = PEA_WID,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [15:0]         cfg_num_vec,
    input  logic [N_PE-1:0]     cfg_lane_mask,
    input  logic                vec_valid,
    input  logic [N_PE*WID-1:0] vec_data,
    output logic                vec_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WID-1:0]      wr_data,
    input  logic                wr_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int VEC_W = N_PE * WID;
    localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;

    state_t             state;
    logic [15:0]        num_vec_q;
    logic [15:0]        accepted;
    logic [N_PE-1:0]    mask_q;
    logic [N_PE-1:0]    rem_q;
    logic [VEC_W-1:0]   cur_vec;
    logic [VEC_W-1:0]   fifo_head;
    logic [VEC_W-1:0]   load_vec;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               handshake;
    logic               ser_free;
    logic               mask_zero;
    logic               accept;
    logic               bypass;
    logic               load;
    logic               load_fifo;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   next_idx;

    // Index of the lowest set bit, used to walk lanes in ascending order
    function automatic logic [IDX_W-1:0] lowest_lane(input logic [N_PE-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_PE - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign handshake = wr_en && wr_ready;
    // Serializer can take a new vector this cycle: idle, or finishing its last lane
    assign ser_free  = !wr_en || (wr_ready && (rem_q == '0));
    assign mask_zero = (mask_q == '0);
    // With an empty mask entries are simply discarded one cycle after push
    assign fifo_pop  = !fifo_empty && (mask_zero || ser_free);
    // Full is judged after this cycle's pop so a simultaneous push still fits
    assign vec_ready = (state == ST_RUN) && (!fifo_full || fifo_pop) && (accepted < num_vec_q);
    assign accept    = vec_valid && vec_ready;
    // An empty FIFO and free serializer let the incoming vector skip the FIFO,
    // which gives the one-cycle accept-to-write latency
    assign bypass    = accept && fifo_empty && ser_free && !mask_zero;
    assign fifo_push = accept && !bypass;
    assign load_fifo = fifo_pop && !mask_zero;
    assign load      = load_fifo || bypass;
    assign load_vec  = load_fifo ? fifo_head : vec_data;
    assign first_idx = lowest_lane(mask_q);
    assign next_idx  = lowest_lane(rem_q);

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    pea_vec_fifo #(
        .DEPTH (DEPTH),
        .W     (VEC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (vec_data),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Lane serializer: holds the current vector and presents one registered write at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
            rem_q   <= '0;
            cur_vec <= '0;
        end else if (load) begin
            cur_vec <= load_vec;
            wr_en   <= 1'b1;
            wr_data <= load_vec[int'(first_idx)*WID +: WID];
            rem_q   <= mask_q & (mask_q - N_PE'(1));
        end else if (handshake) begin
            if (rem_q != '0) begin
                wr_data <= cur_vec[int'(next_idx)*WID +: WID];
                rem_q   <= rem_q & (rem_q - N_PE'(1));
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

    // Job sequencing, address counter, accept counter and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_addr   <= '0;
            num_vec_q <= '0;
            mask_q    <= '0;
            accepted  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (handshake) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            if (vec_valid && !vec_ready && busy) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                accepted <= accepted + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_vec_q <= cfg_num_vec;
                        mask_q    <= cfg_lane_mask;
                        wr_addr   <= cfg_base_addr;
                        accepted  <= '0;
                        overflow  <= 1'b0;
                        state     <= (cfg_num_vec == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accepted == num_vec_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !wr_en) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pea_output_writeback.sv
// Directed self-checking bench for pea_output_writeback.
module tb_pea_output_writeback;

    localparam int N_PE   = 8;
    localparam int WID    = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ADDR_W-1:0]   cfg_base_addr;
    logic [15:0]         cfg_num_vec;
    logic [N_PE-1:0]     cfg_lane_mask;
    logic                vec_valid;
    logic [N_PE*WID-1:0] vec_data;
    logic                vec_ready;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WID-1:0]      wr_data;
    logic                wr_ready;
    logic                busy;
    logic                done;
    logic                overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_en_cnt = 0;
    int done_cnt  = 0;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [WID-1:0]    wq_data[$];

    pea_output_writeback #(
        .N_PE   (N_PE),
        .WID    (WID),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_vec   (cfg_num_vec),
        .cfg_lane_mask (cfg_lane_mask),
        .vec_valid     (vec_valid),
        .vec_data      (vec_data),
        .vec_ready     (vec_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Write-port monitor sampling on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && wr_ready) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
            end
            if (wr_en) wr_en_cnt++;
            if (done)  done_cnt++;
        end
    end

    function automatic logic [N_PE*WID-1:0] vec_of(input int base_val);
        logic [N_PE*WID-1:0] v;
        v = '0;
        for (int i = 0; i < N_PE; i++) v[i*WID +: WID] = WID'(base_val + i);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [15:0] num,
                            input logic [N_PE-1:0] mask);
        cfg_base_addr = base;
        cfg_num_vec   = num;
        cfg_lane_mask = mask;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_vec(input logic [N_PE*WID-1:0] data, output bit ok);
        vec_valid = 1'b1;
        vec_data  = data;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = vec_ready;
            step();
        end
        vec_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = done;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_data = '0; wr_ready = 1'b1;
        cfg_base_addr = '0; cfg_num_vec = '0; cfg_lane_mask = '0;
        step(); step();
        n_checks++; if (vec_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vec_ready: got %0b expected 0", vec_ready); end
        n_checks++; if (wr_en !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", wr_en); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
        n_checks++; if (wr_addr !== '0)     begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        n_checks++; if (wr_data !== '0)     begin n_fail++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_mask();
        bit ok0, ok1, okd;
        int dsnap;
        wr_ready = 1'b1;
        clear_log();
        dsnap = done_cnt;
        do_start(12'h100, 16'd2, 8'hFF);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL full_busy: got %0b expected 1", busy); end
        push_vec(vec_of(0), ok0);
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'h100 || wr_data !== 16'd0) begin
            n_fail++; $display("[TB] FAIL full_latency: got en=%0b addr=%h data=%0d expected en=1 addr=100 data=0", wr_en, wr_addr, wr_data);
        end
        push_vec(vec_of(10), ok1);
        wait_done(100, okd);
        n_checks++; if (!(ok0 && ok1 && okd)) begin n_fail++; $display("[TB] FAIL full_progress: got accept0=%0b accept1=%0b done=%0b expected all 1", ok0, ok1, okd); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL full_busy_end: got %0b expected 0", busy); end
        n_checks++; if (done_cnt - dsnap != 1) begin n_fail++; $display("[TB] FAIL full_done_pulses: got %0d expected 1", done_cnt - dsnap); end
        n_checks++; if (wq_addr.size() != 16) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected 16", wq_addr.size()); end
        for (int k = 0; k < 16 && k < wq_addr.size(); k++) begin
            n_checks++;
            if (wq_addr[k] !== ADDR_W'(32'h100 + k) || wq_data[k] !== WID'((k / 8) * 10 + k % 8)) begin
                n_fail++; $display("[TB] FAIL full_write%0d: got %h@%h expected %h@%h", k, wq_data[k], wq_addr[k], WID'((k / 8) * 10 + k % 8), ADDR_W'(32'h100 + k));
            end
        end
    endtask

    task automatic test_sparse_mask();
        bit ok0, okd;
        logic [WID-1:0] exp_d [4];
        exp_d = '{16'hA0, 16'hA2, 16'hA5, 16'hA7};
        clear_log();
        do_start(12'h200, 16'd1, 8'b1010_0101);
        push_vec(vec_of(32'hA0), ok0);
        wait_done(50, okd);
        n_checks++; if (!(ok0 && okd)) begin n_fail++; $display("[TB] FAIL sparse_progress: got accept=%0b done=%0b expected 1 1", ok0, okd); end
        n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("[TB] FAIL sparse_count: got %0d expected 4", wq_addr.size()); end
        for (int k = 0; k < 4 && k < wq_addr.size(); k++) begin
            n_checks++;
            if (wq_addr[k] !== ADDR_W'(32'h200 + k) || wq_data[k] !== exp_d[k]) begin
                n_fail++; $display("[TB] FAIL sparse_write%0d: got %h@%h expected %h@%h", k, wq_data[k], wq_addr[k], exp_d[k], ADDR_W'(32'h200 + k));
            end
        end
    endtask

    task automatic test_stall();
        int acc = 0;
        int first_drop = -1;
        bit stable = 1'b1;
        bit ok, all_ok, okd;
        wr_ready = 1'b0;
        clear_log();
        do_start(12'h300, 16'd8, 8'hFF);
        for (int c = 0; c < 20; c++) begin
            vec_valid = 1'b1;
            vec_data  = vec_of(c * 16);
            @(negedge clk);
            if (vec_ready) acc++;
            else if (first_drop < 0) first_drop = c;
            if (c > 0 && (wr_en !== 1'b1 || wr_addr !== 12'h300 || wr_data !== 16'd0)) stable = 1'b0;
            step();
        end
        vec_valid = 1'b0;
        n_checks++; if (acc != 5)        begin n_fail++; $display("[TB] FAIL stall_accepts: got %0d expected 5", acc); end
        n_checks++; if (first_drop != 5) begin n_fail++; $display("[TB] FAIL stall_first_drop: got cycle %0d expected 5", first_drop); end
        n_checks++; if (!stable)         begin n_fail++; $display("[TB] FAIL stall_stable: got unstable write port expected held 0000@300"); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_overflow: got %0b expected 1", overflow); end
        wr_ready = 1'b1;
        all_ok = 1'b1;
        for (int v = 5; v < 8; v++) begin
            push_vec(vec_of(v * 16), ok);
            all_ok &= ok;
        end
        wait_done(200, okd);
        n_checks++; if (!(all_ok && okd)) begin n_fail++; $display("[TB] FAIL stall_progress: got accepts=%0b done=%0b expected 1 1", all_ok, okd); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_sticky: got %0b expected 1", overflow); end
        n_checks++; if (wq_addr.size() != 64) begin n_fail++; $display("[TB] FAIL stall_count: got %0d expected 64", wq_addr.size()); end
        for (int k = 0; k < 64 && k < wq_addr.size(); k++) begin
            n_checks++;
            if (wq_addr[k] !== ADDR_W'(32'h300 + k) || wq_data[k] !== WID'((k / 8) * 16 + k % 8)) begin
                n_fail++; $display("[TB] FAIL stall_write%0d: got %h@%h expected %h@%h", k, wq_data[k], wq_addr[k], WID'((k / 8) * 16 + k % 8), ADDR_W'(32'h300 + k));
            end
        end
    endtask

    task automatic test_wrap();
        bit ok0, okd;
        logic [ADDR_W-1:0] exp_a [4];
        exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        clear_log();
        do_start(12'hFFE, 16'd1, 8'h0F);
        push_vec(vec_of(32'h50), ok0);
        wait_done(50, okd);
        n_checks++; if (!(ok0 && okd)) begin n_fail++; $display("[TB] FAIL wrap_progress: got accept=%0b done=%0b expected 1 1", ok0, okd); end
        n_checks++; if (wq_addr.size() != 4) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 4", wq_addr.size()); end
        for (int k = 0; k < 4 && k < wq_addr.size(); k++) begin
            n_checks++;
            if (wq_addr[k] !== exp_a[k] || wq_data[k] !== WID'(32'h50 + k)) begin
                n_fail++; $display("[TB] FAIL wrap_write%0d: got %h@%h expected %h@%h", k, wq_data[k], wq_addr[k], WID'(32'h50 + k), exp_a[k]);
            end
        end
    endtask

    task automatic test_zero_jobs();
        int esnap;
        bit ok, all_ok, okd;
        esnap = wr_en_cnt;
        do_start(12'h000, 16'd0, 8'hFF);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_num_done: got %0b expected 1", done); end
        step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_num_after: got done=%0b busy=%0b expected 0 0", done, busy); end
        clear_log();
        do_start(12'h020, 16'd3, 8'h00);
        all_ok = 1'b1;
        for (int v = 0; v < 3; v++) begin
            push_vec(vec_of(v), ok);
            all_ok &= ok;
        end
        wait_done(50, okd);
        n_checks++; if (!(all_ok && okd)) begin n_fail++; $display("[TB] FAIL zero_mask_progress: got accepts=%0b done=%0b expected 1 1", all_ok, okd); end
        n_checks++; if (wr_en_cnt != esnap || wq_addr.size() != 0) begin n_fail++; $display("[TB] FAIL zero_no_writes: got %0d wr_en cycles expected 0", wr_en_cnt - esnap); end
    endtask

    task automatic test_reset_mid_job();
        bit ok0, okd;
        int esnap;
        wr_ready = 1'b1;
        clear_log();
        do_start(12'h400, 16'd2, 8'hFF);
        push_vec(vec_of(32'h40), ok0);
        for (int i = 0; i < 20 && wq_addr.size() < 2; i++) step();
        rst = 1'b1;
        wr_ready = 1'b0;
        step();
        n_checks++; if (wq_addr.size() != 2) begin n_fail++; $display("[TB] FAIL midrst_writes_before: got %0d expected 2", wq_addr.size()); end
        n_checks++;
        if ({vec_ready, wr_en, busy, done, overflow, wr_addr, wr_data} !== '0) begin
            n_fail++; $display("[TB] FAIL midrst_outputs: got ready=%0b en=%0b busy=%0b done=%0b ovf=%0b addr=%h data=%h expected all 0", vec_ready, wr_en, busy, done, overflow, wr_addr, wr_data);
        end
        rst = 1'b0;
        wr_ready = 1'b1;
        esnap = wr_en_cnt;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (wr_en_cnt != esnap) begin n_fail++; $display("[TB] FAIL midrst_no_wr: got %0d wr_en cycles expected 0", wr_en_cnt - esnap); end
        clear_log();
        do_start(12'h010, 16'd1, 8'h03);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_overflow: got %0b expected 0", overflow); end
        push_vec(vec_of(32'h70), ok0);
        wait_done(50, okd);
        n_checks++; if (!(ok0 && okd)) begin n_fail++; $display("[TB] FAIL midrst_progress: got accept=%0b done=%0b expected 1 1", ok0, okd); end
        n_checks++;
        if (wq_addr.size() != 2) begin
            n_fail++; $display("[TB] FAIL midrst_fresh_count: got %0d expected 2", wq_addr.size());
        end else if (wq_addr[0] !== 12'h010 || wq_data[0] !== 16'h70 || wq_addr[1] !== 12'h011 || wq_data[1] !== 16'h71) begin
            n_fail++; $display("[TB] FAIL midrst_fresh_writes: got %h@%h %h@%h expected 0070@010 0071@011", wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
        end
    endtask

    initial begin
        $display("[TB] starting pea_output_writeback bench");
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_stall();
        test_wrap();
        test_zero_jobs();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pea_output_writeback.md
Name: pea_output_writeback

Overview:
Downstream stage of the PE array. Captures one full vector of per-PE output words per strobe into a small vector FIFO. Serializes the enabled lanes into single-word writes towards the output feature-map buffer, with a valid/ready write handshake and an incrementing address. Reports busy, done and a sticky overflow, because the PE array cannot be stalled.

Parameters:
- N_PE, 8: number of lanes (PE outputs per vector); matches `N_PE.
- WID, 16: bits per lane word; matches `WID_PE_BITS.
- DEPTH, 4: vector FIFO depth in vectors; power of two, at least 2.
- ADDR_W, 12: output buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse that latches cfg_* and begins a job.
- cfg_base_addr  in  ADDR_W  first write address.
- cfg_num_vec  in  16  number of vectors to collect in this job.
- cfg_lane_mask  in  N_PE  bit i=1 means lane i is written.
- vec_valid  in  1  PE array output vector valid this cycle.
- vec_data  in  N_PE*WID  lane i occupies bits [i*WID +: WID].
- vec_ready  out  1  a vector would be accepted this cycle.
- wr_en  out  1  write request valid.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  WID  write data.
- wr_ready  in  1  buffer accepts the write when wr_en && wr_ready.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.
- overflow  out  1  sticky flag: a vector was dropped.

Behaviour:
- Reset: state IDLE; FIFO empty; counters 0; vec_ready, wr_en, busy, done and overflow all 0; wr_addr=0; wr_data=0. Reset mid-job abandons the job with no further writes.
- FSM states and transitions:
  - IDLE: start latches config, sets addr=cfg_base_addr and accepted=0, and moves to RUN. If cfg_num_vec=0, go instead to DONE.
  - RUN: accept vectors; when accepted==cfg_num_vec, go to DRAIN.
  - DRAIN: when the FIFO is empty and the serializer is idle, go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- busy=1 in RUN and DRAIN.
- vec_ready=1 only in RUN with the FIFO not full and accepted<cfg_num_vec.
- vec_valid && vec_ready: push vector; accepted+1.
- vec_valid && !vec_ready in RUN or DRAIN: vector dropped, overflow←1. overflow is cleared only by rst or start.
- vec_valid in IDLE or DONE: ignored, no flag.
- Serializer pops the FIFO head and walks the set mask bits in ascending lane order, one write per lane.
  - wr_en, wr_addr and wr_data are registered and held stable until wr_ready.
  - On handshake: addr+1 modulo 2^ADDR_W (wrap is silent), then advance to the next set lane.
  - After the last set lane the entry is freed. The next entry's first write may issue in the cycle immediately after, so there are no bubbles with wr_ready held at 1.
- Latency: vector accepted at cycle t gives its first wr_en at t+1. Steady state is popcount(mask) cycles per vector when wr_ready=1.
- Mask all zero: each entry is popped one cycle after push and wr_en is never asserted. Job completes normally.
- Total writes per job = cfg_num_vec × popcount(cfg_lane_mask).
- Simultaneous push and pop on a full FIFO: the push is accepted, since full is evaluated after the pop frees a slot.
- start while busy: ignored; config is unchanged.
- wr_ready asserted while wr_en=0: no effect.

Decomposition:
- Shared package pea_wb_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - lane-word typedef logic [WID-1:0];
  - vector typedef as an array of N_PE lane words.
- One sub-module, pea_vec_fifo: a synchronous DEPTH×(N_PE*WID) FIFO with push, pop, full, empty and head outputs. The serializer and FSM stay in the top module.

Test Plan:
- Reset, then start with base=0x100, num_vec=2, mask=0xFF, and wr_ready=1. Push two vectors whose lane i holds 10*v+i. Expect 16 writes at 0x100..0x10F with data 0..7 then 10..17, then done pulses once and busy drops.
- mask=0b1010_0101, num_vec=1, lanes hold 0xA0+i. Expect 4 writes: 0xA0@base, 0xA2@base+1, 0xA5@base+2, 0xA7@base+3.
- wr_ready=0 for 20 cycles, pushing vectors every cycle with num_vec=8. Expect vec_ready to drop after 4 vectors (DEPTH) plus 1 vector held in the serializer. The next vec_valid sets overflow, and wr_en, wr_addr and wr_data stay stable throughout the stall.
- base=0xFFE, mask=0x0F, num_vec=1. Expect writes to 0xFFE, 0xFFF, 0x000, 0x001.
- num_vec=0: expect done one cycle after start and no wr_en. mask=0: with num_vec=3, expect 3 accepts, no writes, then done.
- Assert rst mid-job, two writes into a vector. Expect all outputs at reset values the next cycle and no further wr_en. A fresh start then runs cleanly with overflow=0.
